counter8_seq: RTL and testbench

//  Command sequencer directly upstream of the 8-bit up/down counter.

---
 rtl/counter8_seq_if.sv | 14 +
 rtl/counter8_seq.sv | 122 ++++++++++++
 tb/tb_counter8_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/counter8_seq_if.sv
// Job command channel into the counter sequencer: valid/ready handshake plus job fields.
interface counter8_seq_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic             CMD_DIR;
  logic [WIDTH-1:0] CMD_START;
  logic [LEN_W-1:0] CMD_LEN;

  modport master (output CMD_VALID, CMD_DIR, CMD_START, CMD_LEN, input  CMD_READY);
  modport slave  (input  CMD_VALID, CMD_DIR, CMD_START, CMD_LEN, output CMD_READY);
endinterface

// File: rtl/counter8_seq.sv
// Sequencer that runs one load/count/check job on an external 8-bit up/down counter
// and verifies the counter's final value against start +/- len.
module counter8_seq #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RESETn,
  counter8_seq_if.slave    cmd,
  input  logic             PAUSE,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] CNT_DOUT,
  output logic             MODE_SEL,
  output logic             LOAD,
  output logic [WIDTH-1:0] DIN,
  output logic             INC_START,
  output logic             INC_END,
  output logic             DEC_START,
  output logic             DEC_END,
  output logic             HOLD,
  output logic             CLR,
  output logic             BUSY,
  output logic             DONE,
  output logic             MISMATCH,
  output logic             ABORTED
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_STOP, S_CHECK} state_t;

  state_t           state, state_nx;
  logic             dir_q;
  logic [WIDTH-1:0] start_q, exp_q, len_ext;
  logic [LEN_W-1:0] len_q, rem_q, rem_nx;
  logic             accept, abort_take;

  assign accept     = (state == S_IDLE) & cmd.CMD_VALID;
  assign abort_take = (state != S_IDLE) & ABORT;
  assign len_ext    = WIDTH'(cmd.CMD_LEN);

  assign cmd.CMD_READY = (state == S_IDLE);
  assign BUSY          = (state != S_IDLE);
  assign MODE_SEL      = dir_q;  // dir_q only changes on accept, so it holds through IDLE
  assign DIN           = start_q;
  assign HOLD          = PAUSE & (state == S_RUN);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= S_IDLE;
      dir_q   <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
    end else begin
      state <= state_nx;
      rem_q <= rem_nx;
      if (accept) begin
        dir_q   <= cmd.CMD_DIR;
        start_q <= cmd.CMD_START;
        len_q   <= cmd.CMD_LEN;
        exp_q   <= cmd.CMD_DIR ? cmd.CMD_START + len_ext : cmd.CMD_START - len_ext;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rem_nx    = rem_q;
    LOAD      = 1'b0;
    INC_START = 1'b0;
    INC_END   = 1'b0;
    DEC_START = 1'b0;
    DEC_END   = 1'b0;
    CLR       = 1'b0;
    DONE      = 1'b0;
    MISMATCH  = 1'b0;
    ABORTED   = 1'b0;
    case (state)
      S_IDLE:  if (cmd.CMD_VALID) state_nx = S_LOAD;
      S_LOAD: begin
        LOAD     = 1'b1;
        state_nx = (len_q == '0) ? S_CHECK : S_ARM;
      end
      S_ARM: begin
        INC_START = dir_q;
        DEC_START = ~dir_q;
        rem_nx    = len_q - LEN_W'(1);
        state_nx  = (len_q == LEN_W'(1)) ? S_STOP : S_RUN;
      end
      // rem counts the unpaused RUN cycles left; STOP supplies the final step
      S_RUN: begin
        if (!PAUSE) begin
          rem_nx = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        INC_END  = dir_q;
        DEC_END  = ~dir_q;
        state_nx = S_CHECK;
      end
      S_CHECK: begin
        DONE     = 1'b1;
        MISMATCH = (CNT_DOUT != exp_q);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Abort overrides any pulse scheduled for this cycle; the counter clear wipes its state.
    if (abort_take) begin
      LOAD      = 1'b0;
      INC_START = 1'b0;
      INC_END   = 1'b0;
      DEC_START = 1'b0;
      DEC_END   = 1'b0;
      DONE      = 1'b0;
      MISMATCH  = 1'b0;
      CLR       = 1'b1;
      ABORTED   = 1'b1;
      state_nx  = S_IDLE;
    end
  end
endmodule

// File: tb/tb_counter8_seq.sv
// Bench for counter8_seq: a behavioural up/down counter closes the loop; job vectors
// come from a table, abort / back-to-back / reset cases are hand sequenced.
module tb_counter8_seq;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       PAUSE = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] CNT_DOUT, DIN;
  logic       MODE_SEL, LOAD, INC_START, INC_END, DEC_START, DEC_END;
  logic       HOLD, CLR, BUSY, DONE, MISMATCH, ABORTED;

  counter8_seq_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) cmd ();

  counter8_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESETn(RESETn), .cmd(cmd), .PAUSE(PAUSE), .ABORT(ABORT),
    .CNT_DOUT(CNT_DOUT), .MODE_SEL(MODE_SEL), .LOAD(LOAD), .DIN(DIN),
    .INC_START(INC_START), .INC_END(INC_END), .DEC_START(DEC_START), .DEC_END(DEC_END),
    .HOLD(HOLD), .CLR(CLR), .BUSY(BUSY), .DONE(DONE), .MISMATCH(MISMATCH), .ABORTED(ABORTED)
  );

  always #5 CLK = ~CLK;

  // Behavioural counter: START sets enable, END clears it after that edge's step.
  logic [7:0] cnt;
  logic       en_up, en_dn;
  logic       force_zero = 1'b0;
  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt <= 8'h00; en_up <= 1'b0; en_dn <= 1'b0;
    end else if (CLR) begin
      cnt <= 8'h00; en_up <= 1'b0; en_dn <= 1'b0;
    end else begin
      if (LOAD) cnt <= DIN;
      else if ((en_up | en_dn) && !HOLD) cnt <= MODE_SEL ? cnt + 8'd1 : cnt - 8'd1;
      if (INC_START) en_up <= 1'b1; else if (INC_END) en_up <= 1'b0;
      if (DEC_START) en_dn <= 1'b1; else if (DEC_END) en_dn <= 1'b0;
    end
  end
  assign CNT_DOUT = force_zero ? 8'h00 : cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  typedef struct {
    logic       dir;
    logic [7:0] start;
    logic [7:0] len;
    int         p_from, p_num;
    int         lat;
    logic [7:0] dout;
    int         inc_s, inc_e, dec_s, dec_e, hold;
  } vec_t;

  function automatic logic [20:0] out_vec();
    return {cmd.CMD_READY, BUSY, MODE_SEL, LOAD, INC_START, INC_END, DEC_START, DEC_END,
            HOLD, CLR, DONE, MISMATCH, ABORTED, DIN};
  endfunction

  task automatic accept_job(input logic d, input logic [7:0] st, input logic [7:0] ln);
    @(negedge CLK);
    cmd.CMD_VALID = 1'b1; cmd.CMD_DIR = d; cmd.CMD_START = st; cmd.CMD_LEN = ln;
    @(negedge CLK);
    cmd.CMD_VALID = 1'b0; cmd.CMD_DIR = ~d; cmd.CMD_START = 8'h5A; cmd.CMD_LEN = 8'h33;
  endtask

  task automatic run_job(input vec_t v, output int lat, output logic [7:0] dout, output logic mm,
                         output int is_, output int ie, output int ds, output int de,
                         output int hd, output logic ms_ok, output logic excl_ok);
    lat = -1; dout = 8'h00; mm = 1'b0; is_ = 0; ie = 0; ds = 0; de = 0; hd = 0;
    ms_ok = 1'b1; excl_ok = 1'b1;
    accept_job(v.dir, v.start, v.len);
    for (int k = 1; k <= 300; k++) begin
      PAUSE = (k >= v.p_from) && (k < v.p_from + v.p_num);
      #1;
      is_ += int'(INC_START); ie += int'(INC_END);
      ds  += int'(DEC_START); de += int'(DEC_END); hd += int'(HOLD);
      if (MODE_SEL !== v.dir) ms_ok = 1'b0;
      if ((INC_START | INC_END) && (DEC_START | DEC_END)) excl_ok = 1'b0;
      if ((INC_START | DEC_START) && (INC_END | DEC_END)) excl_ok = 1'b0;
      if (DONE) begin
        lat = k; dout = CNT_DOUT; mm = MISMATCH;
        break;
      end
      @(negedge CLK);
    end
    PAUSE = 1'b0;
  endtask

  localparam logic [20:0] RST_OUT = {1'b1, 12'b0, 8'h00};

  initial begin
    vec_t       vecs[6];
    int         lat, is_, ie, ds, de, hd, dcnt;
    logic [7:0] dout;
    logic       mm, ms_ok, excl_ok;

    //         dir   start  len    pf pn  lat dout   is ie ds de hold
    vecs[0] = '{1'b1, 8'h10, 8'd5,   0, 0, 8,   8'h15, 1, 1, 0, 0, 0};
    vecs[1] = '{1'b0, 8'h01, 8'd3,   0, 0, 6,   8'hFE, 0, 0, 1, 1, 0};
    vecs[2] = '{1'b1, 8'hA5, 8'd0,   0, 0, 2,   8'hA5, 0, 0, 0, 0, 0};
    vecs[3] = '{1'b1, 8'h00, 8'd4,   3, 2, 9,   8'h04, 1, 1, 0, 0, 2};
    vecs[4] = '{1'b1, 8'hFF, 8'd1,   0, 0, 4,   8'h00, 1, 1, 0, 0, 0};
    vecs[5] = '{1'b0, 8'h80, 8'd255, 0, 0, 258, 8'h81, 0, 0, 1, 1, 0};

    cmd.CMD_VALID = 1'b0; cmd.CMD_DIR = 1'b0; cmd.CMD_START = 8'h00; cmd.CMD_LEN = 8'h00;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_outputs", 32'(out_vec()), 32'(RST_OUT));
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    check("post_reset_outputs", 32'(out_vec()), 32'(RST_OUT));

    foreach (vecs[i]) begin
      run_job(vecs[i], lat, dout, mm, is_, ie, ds, de, hd, ms_ok, excl_ok);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].dout));
      check($sformatf("v%0d_mismatch", i), 32'(mm), 32'd0);
      check($sformatf("v%0d_pulses", i), {8'(is_), 8'(ie), 8'(ds), 8'(de)},
            {8'(vecs[i].inc_s), 8'(vecs[i].inc_e), 8'(vecs[i].dec_s), 8'(vecs[i].dec_e)});
      check($sformatf("v%0d_hold", i), 32'(hd), 32'(vecs[i].hold));
      check($sformatf("v%0d_mode_sel", i), 32'(ms_ok), 32'd1);
      check($sformatf("v%0d_pin_exclusive", i), 32'(excl_ok), 32'd1);
    end

    // MODE_SEL keeps the last job's direction while idle (last job counted down)
    @(negedge CLK); #1;
    check("idle_mode_sel_held", 32'(MODE_SEL), 32'd0);

    // Abort mid-RUN of an up len=10 job
    accept_job(1'b1, 8'h30, 8'd10);
    repeat (3) @(negedge CLK);
    ABORT = 1'b1;
    #1;
    check("abort_run_clr_aborted", {30'd0, CLR, ABORTED}, 32'd3);
    check("abort_run_no_pulses", {28'd0, DONE, INC_END, DEC_END, LOAD}, 32'd0);
    @(negedge CLK);
    ABORT = 1'b0;
    #1;
    check("abort_run_idle_next", {30'd0, cmd.CMD_READY, ABORTED}, 32'd2);
    check("abort_run_dout_cleared", 32'(CNT_DOUT), 32'd0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK); #1;
      dcnt += int'(DONE);
    end
    check("abort_run_no_done", 32'(dcnt), 32'd0);

    // Abort in IDLE is ignored
    @(negedge CLK);
    ABORT = 1'b1;
    #1;
    check("abort_idle_ignored", {30'd0, CLR, ABORTED}, 32'd0);
    @(negedge CLK);
    ABORT = 1'b0;
    #1;
    check("abort_idle_ready", 32'(cmd.CMD_READY), 32'd1);

    // Abort landing on the CHECK cycle suppresses DONE
    accept_job(1'b1, 8'h77, 8'd0);
    @(negedge CLK);
    ABORT = 1'b1;
    #1;
    check("abort_check_done_suppressed", {29'd0, DONE, CLR, ABORTED}, 32'd3);
    @(negedge CLK);
    ABORT = 1'b0;
    #1;
    check("abort_check_idle_cleared", {23'd0, cmd.CMD_READY, CNT_DOUT}, {23'd0, 1'b1, 8'h00});

    // Back-to-back: up 0x20/2 then down 0x20/2 with DOUT forced to 0 for the second
    accept_job(1'b1, 8'h20, 8'd2);
    repeat (4) @(negedge CLK);
    #1;
    check("b2b_first_done", {22'd0, DONE, MISMATCH, CNT_DOUT}, {22'd0, 1'b1, 1'b0, 8'h22});
    @(negedge CLK);
    cmd.CMD_VALID = 1'b1; cmd.CMD_DIR = 1'b0; cmd.CMD_START = 8'h20; cmd.CMD_LEN = 8'd2;
    #1;
    check("b2b_ready_after_done", 32'(cmd.CMD_READY), 32'd1);
    @(negedge CLK);
    cmd.CMD_VALID = 1'b0;
    force_zero = 1'b1;
    #1;
    check("b2b_second_accepted", {30'd0, LOAD, BUSY}, 32'd3);
    repeat (4) @(negedge CLK);
    #1;
    check("b2b_forced_mismatch", {30'd0, DONE, MISMATCH}, 32'd3);
    @(negedge CLK);
    force_zero = 1'b0;

    // Asynchronous reset in the middle of a job
    accept_job(1'b1, 8'h40, 8'd20);
    repeat (5) @(negedge CLK);
    RESETn = 1'b0;
    #1;
    check("async_reset_outputs", 32'(out_vec()), 32'(RST_OUT));
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    check("async_reset_idle", {23'd0, cmd.CMD_READY, CNT_DOUT}, {23'd0, 1'b1, 8'h00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
